// File: rtl/matrix_mode_fsm_if.sv
// Handshake/bus bundle for the matrix calculator mode controller.
//   master : the mode controller (consumes buttons, switches, engine status;
//            produces display state and the engine launch pulse)
//   slave  : the surrounding board logic / engines / display
// Signals:
//   btn_confirm, btn_back   raw push-buttons (asynchronous, active-high)
//   sw_mode[2:0], sw_op[3:0] mode / operation switches
//   task_done, task_err     one-cycle engine status pulses
//   task_err_code[3:0]      engine error code, valid with task_err
//   main_state[2:0], sub_state[3:0], op_type[3:0], error_code[3:0]
//                           display-facing state
//   task_start              one-cycle engine launch pulse
interface matrix_mode_fsm_if;
  logic       btn_confirm;
  logic       btn_back;
  logic [2:0] sw_mode;
  logic [3:0] sw_op;
  logic       task_done;
  logic       task_err;
  logic [3:0] task_err_code;
  logic [2:0] main_state;
  logic [3:0] sub_state;
  logic [3:0] op_type;
  logic [3:0] error_code;
  logic       task_start;

  modport master (
    input  btn_confirm, btn_back, sw_mode, sw_op,
           task_done, task_err, task_err_code,
    output main_state, sub_state, op_type, error_code, task_start
  );

  modport slave (
    output btn_confirm, btn_back, sw_mode, sw_op,
           task_done, task_err, task_err_code,
    input  main_state, sub_state, op_type, error_code, task_start
  );
endinterface

// File: rtl/matrix_mode_fsm.sv
// Top-level mode controller for the matrix calculator.
// Debounces confirm/back, samples mode/op switches on a confirm press, runs the
// main/sub state machine, issues task_start to the engine selected by
// main_state and tracks engine completion/error. All outputs are registered.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    matrix_mode_fsm_if.master (buttons, switches, engine handshake,
//          display state outputs)
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a button level is accepted
//   ERR_HOLD_CYCLES  cycles a nonzero error_code stays visible
module matrix_mode_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned ERR_HOLD_CYCLES = 300_000_000
) (
  input logic               clk,
  input logic               rst_n,
  matrix_mode_fsm_if.master bus
);
  localparam int NBTN = 2;
  localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int EHW  = (ERR_HOLD_CYCLES > 1) ? $clog2(ERR_HOLD_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  // Timer is loaded with HOLD-1 and clears the error when it is seen at 0,
  // so the code is visible for exactly ERR_HOLD_CYCLES cycles.
  localparam logic [EHW-1:0] HOLD_LD = EHW'(ERR_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    M_MENU = 3'd0, M_INPUT = 3'd1, M_GEN = 3'd2,
    M_DISP = 3'd3, M_COMP = 3'd4, M_SET = 3'd5
  } main_e;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_RUN = 4'd1, S_DONE = 4'd2, S_ERR = 4'd3
  } sub_e;

  // ---------------- button front end (bit 0 confirm, bit 1 back) ----------
  logic [NBTN-1:0] btn_raw, press;
  logic            p_conf, p_back;

  assign btn_raw = {bus.btn_back, bus.btn_confirm};

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    logic           s1, s2, db, db_d;
    logic [DBW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1   <= 1'b0;
        s2   <= 1'b0;
        db   <= 1'b0;
        db_d <= 1'b0;
        cnt  <= '0;
      end else begin
        s1   <= btn_raw[i];
        s2   <= s1;
        db_d <= db;
        if (s2 == db) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          db  <= ~db;
          cnt <= '0;
        end else begin
          cnt <= cnt + DBW'(1);
        end
      end
    end

    assign press[i] = db & ~db_d;
  end

  // Back has priority over a confirm arriving in the same cycle.
  assign p_back = press[1];
  assign p_conf = press[0] & ~press[1];

  // ---------------- main/sub state machine --------------------------------
  main_e          main_q;
  sub_e           sub_q;
  logic [3:0]     op_q;
  logic [3:0]     err_q;
  logic [EHW-1:0] tmr_q;
  logic           start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q  <= M_MENU;
      sub_q   <= S_IDLE;
      op_q    <= 4'd0;
      err_q   <= 4'd0;
      tmr_q   <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;

      // Hold timer; any event below that writes error_code overrides this.
      if (err_q != 4'd0) begin
        if (tmr_q == '0) begin
          err_q <= 4'd0;
          if (sub_q == S_ERR) sub_q <= S_IDLE;
        end else begin
          tmr_q <= tmr_q - EHW'(1);
        end
      end

      if (main_q == M_MENU) begin
        if (p_conf) begin
          if (bus.sw_mode inside {[3'd1:3'd5]}) begin
            main_q <= main_e'(bus.sw_mode);
            sub_q  <= S_IDLE;
            err_q  <= 4'd0;
          end else begin
            err_q <= 4'd1;
            tmr_q <= HOLD_LD;
          end
        end
      end else begin
        case (sub_q)
          S_IDLE: begin
            if (p_back) begin
              main_q <= M_MENU;
              err_q  <= 4'd0;
            end else if (p_conf) begin
              if (main_q != M_COMP) begin
                start_q <= 1'b1;
                sub_q   <= S_RUN;
              end else if (bus.sw_op <= 4'd4) begin
                op_q    <= bus.sw_op;
                start_q <= 1'b1;
                sub_q   <= S_RUN;
              end else begin
                err_q <= 4'd2;
                tmr_q <= HOLD_LD;
              end
            end
          end
          S_RUN: begin
            if (bus.task_err) begin
              sub_q <= S_ERR;
              err_q <= (bus.task_err_code == 4'd0) ? 4'hF : bus.task_err_code;
              tmr_q <= HOLD_LD;
            end else if (bus.task_done) begin
              sub_q <= S_DONE;
            end
          end
          S_DONE: begin
            if (p_back) begin
              main_q <= M_MENU;
              sub_q  <= S_IDLE;
              err_q  <= 4'd0;
            end else if (p_conf) begin
              sub_q <= S_IDLE;
            end
          end
          S_ERR: begin
            if (p_back) begin
              main_q <= M_MENU;
              sub_q  <= S_IDLE;
              err_q  <= 4'd0;
            end else if (p_conf) begin
              sub_q <= S_IDLE;
              err_q <= 4'd0;
            end
          end
          default: sub_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.main_state = main_q;
  assign bus.sub_state  = sub_q;
  assign bus.op_type    = op_q;
  assign bus.error_code = err_q;
  assign bus.task_start = start_q;
endmodule

// File: tb/tb_matrix_mode_fsm.sv
// Self-checking bench for matrix_mode_fsm (DEBOUNCE_CYCLES=4, ERR_HOLD_CYCLES=20).
// A behavioural model works on press events: a button held for at least D
// cycles yields one press that acts a fixed latency after the raw rise; the
// model applies the mode rules to those events and compares every cycle.
module tb_matrix_mode_fsm;
  localparam int D    = 4;
  localparam int H    = 20;
  localparam int MAXC = 40000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_mode_fsm_if bus();

  matrix_mode_fsm #(.DEBOUNCE_CYCLES(D), .ERR_HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_vec = 0, n_miss = 0;
  int cyc = 0;
  bit pc_sched [0:MAXC-1];
  bit pb_sched [0:MAXC-1];
  bit rand_eng = 1'b0;

  // model state
  int m_main = 0, m_sub = 0, m_op = 0, m_err = 0, m_start = 0;
  int err_deadline = 0;
  bit pc, pb;

  // observed-behaviour counters
  int n_start = 0, err_run = 0, last_err_run = 0;
  bit prev_start = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model --------------------------------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_main = 0; m_sub = 0; m_op = 0; m_err = 0; m_start = 0;
    end else begin
      cyc++;
      pb = pb_sched[cyc];
      pc = pc_sched[cyc] && !pb;
      m_start = 0;
      // error visible for exactly H cycles after the edge that wrote it
      if (m_err != 0 && cyc == err_deadline) begin
        m_err = 0;
        if (m_sub == 3) m_sub = 0;
      end
      if (m_main == 0) begin
        if (pc) begin
          if (bus.sw_mode >= 1 && bus.sw_mode <= 5) begin
            m_main = int'(bus.sw_mode); m_sub = 0; m_err = 0;
          end else begin
            m_err = 1; err_deadline = cyc + H;
          end
        end
      end else begin
        case (m_sub)
          0: if (pb) begin
               m_main = 0; m_err = 0;
             end else if (pc) begin
               if (m_main != 4) begin
                 m_start = 1; m_sub = 1;
               end else if (bus.sw_op <= 4) begin
                 m_op = int'(bus.sw_op); m_start = 1; m_sub = 1;
               end else begin
                 m_err = 2; err_deadline = cyc + H;
               end
             end
          1: if (bus.task_err) begin
               m_sub = 3;
               m_err = (bus.task_err_code == 0) ? 15 : int'(bus.task_err_code);
               err_deadline = cyc + H;
             end else if (bus.task_done) begin
               m_sub = 2;
             end
          2: if (pb) begin m_main = 0; m_sub = 0; m_err = 0; end
             else if (pc) m_sub = 0;
          default: if (pb) begin m_main = 0; m_sub = 0; m_err = 0; end
             else if (pc) begin m_sub = 0; m_err = 0; end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("main_state", int'(bus.main_state), m_main);
      chk("sub_state",  int'(bus.sub_state),  m_sub);
      chk("op_type",    int'(bus.op_type),    m_op);
      chk("error_code", int'(bus.error_code), m_err);
      chk("task_start", int'(bus.task_start), m_start);
      if (prev_start) chk("start_back_to_back", int'(bus.task_start), 0);
      prev_start = bus.task_start;
      if (bus.task_start) n_start++;
      if (bus.error_code != 0) err_run++;
      else begin
        if (err_run != 0) last_err_run = err_run;
        err_run = 0;
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    int r;
    @(negedge clk);
    if (rand_eng) begin
      r = $urandom_range(0, 19);
      bus.task_done     = (r < 3);
      bus.task_err      = (r == 0) || (r == 3);
      bus.task_err_code = 4'($urandom_range(0, 15));
    end else begin
      bus.task_done = 1'b0;
      bus.task_err  = 1'b0;
    end
  endtask

  // Hold the selected raw buttons for len cycles, then release long enough
  // for the debounced level to fall again.
  task automatic press(input bit c, input bit b, input int len);
    for (int i = 0; i < len; i++) begin
      tick();
      if (i == 0 && len >= D) begin
        if (c) pc_sched[cyc + D + 3] = 1'b1;
        if (b) pb_sched[cyc + D + 3] = 1'b1;
      end
      bus.btn_confirm = c;
      bus.btn_back    = b;
    end
    tick();
    bus.btn_confirm = 1'b0;
    bus.btn_back    = 1'b0;
    repeat (D + 4) tick();
  endtask

  task automatic pulse(input bit d, input bit e, input logic [3:0] code);
    tick();
    bus.task_done = d; bus.task_err = e; bus.task_err_code = code;
    tick();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_main"},  int'(bus.main_state), 0);
    chk({tag, "_sub"},   int'(bus.sub_state),  0);
    chk({tag, "_op"},    int'(bus.op_type),    0);
    chk({tag, "_err"},   int'(bus.error_code), 0);
    chk({tag, "_start"}, int'(bus.task_start), 0);
  endtask

  int s0;

  initial begin
    bus.btn_confirm = 0; bus.btn_back = 0; bus.sw_mode = 0; bus.sw_op = 0;
    bus.task_done = 0; bus.task_err = 0; bus.task_err_code = 0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // mode select with a long confirm hold: COMPUTE/IDLE, no start
    s0 = n_start;
    bus.sw_mode = 3'd4;
    press(1, 0, 10);
    chk("enter_compute_main", int'(bus.main_state), 4);
    chk("enter_compute_sub", int'(bus.sub_state), 0);
    chk("enter_compute_nostart", n_start - s0, 0);

    // launch multiply, finish, back to menu
    bus.sw_op = 4'd3;
    press(1, 0, 6);
    chk("launch_one_start", n_start - s0, 1);
    chk("launch_op", int'(bus.op_type), 3);
    chk("launch_sub", int'(bus.sub_state), 1);
    pulse(1, 0, 4'd0);
    chk("done_sub", int'(bus.sub_state), 2);
    press(0, 1, 6);
    chk("back_main", int'(bus.main_state), 0);
    chk("back_op_kept", int'(bus.op_type), 3);

    // invalid mode error held for exactly H cycles
    bus.sw_mode = 3'd7;
    press(1, 0, 6);
    chk("badmode_err", int'(bus.error_code), 1);
    repeat (H + 5) tick();
    chk("badmode_err_len", last_err_run, H);
    chk("badmode_err_clear", int'(bus.error_code), 0);
    chk("badmode_main", int'(bus.main_state), 0);

    // simultaneous done+err with code 0 -> ERR / F
    bus.sw_mode = 3'd4;
    press(1, 0, 6);
    bus.sw_op = 4'd1;
    press(1, 0, 6);
    chk("run2_sub", int'(bus.sub_state), 1);
    pulse(1, 1, 4'd0);
    chk("err_sub", int'(bus.sub_state), 3);
    chk("err_code_f", int'(bus.error_code), 15);
    press(1, 0, 6);
    chk("err_ack_sub", int'(bus.sub_state), 0);
    chk("err_ack_code", int'(bus.error_code), 0);

    // glitch and simultaneous press in INPUT/IDLE
    press(0, 1, 6);
    bus.sw_mode = 3'd1;
    press(1, 0, 6);
    s0 = n_start;
    press(1, 0, 2);
    chk("glitch_main", int'(bus.main_state), 1);
    chk("glitch_sub", int'(bus.sub_state), 0);
    press(1, 1, 6);
    chk("both_main", int'(bus.main_state), 0);
    chk("both_nostart", n_start - s0, 0);

    // asynchronous reset during RUN
    press(1, 0, 6);
    press(1, 0, 6);
    chk("prereset_sub", int'(bus.sub_state), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    s0 = n_start;
    pulse(1, 0, 4'd0);
    repeat (3) tick();
    chk("postreset_main", int'(bus.main_state), 0);
    chk("postreset_sub", int'(bus.sub_state), 0);
    chk("postreset_nostart", n_start - s0, 0);

    // randomized phase: model checks every cycle
    rand_eng = 1'b1;
    for (int it = 0; it < 250; it++) begin
      int act;
      act = $urandom_range(0, 9);
      bus.sw_mode = 3'($urandom_range(0, 7));
      bus.sw_op   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15))
                                                : 4'($urandom_range(0, 4));
      case (act)
        0, 1, 2, 3: press(1, 0, $urandom_range(D, D + 3));
        4, 5:       press(0, 1, $urandom_range(D, D + 3));
        6:          press(1, 1, $urandom_range(D, D + 3));
        7:          press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(1, D - 1));
        default:    repeat ($urandom_range(1, 25)) tick();
      endcase
    end
    rand_eng = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
